instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Instruction fetch front end feeding `instructionDecode`. Fetches 32-bit instructions from instruction memory over a hold-until-ready handshake and buffers them with their word PCs in a small FIFO. Presents each one to the decoder as `instr`/`pcNumber`/`available` one cycle before a single-cycle `decodePulse`, so the decoder samples stable operands. Supports a pipeline redirect for branches and jumps that flushes all fetched and in-flight work.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `RESET_PC`, 32'h0: word-indexed PC fetched first after reset.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memReq`  out  1  instruction read request, held until `memReady`.
- `memAddr`  out  32  byte address, `{fetchPc[29:0],2'b00}`; stable while `memReq`.
- `memReady`  in  1  response valid; `memData` valid this cycle.
- `memData`  in  32  instruction word.
- `redirectValid`  in  1  single-cycle flush request.
- `redirectPc`  in  32  word-indexed target PC.
- `issueReady`  in  1  ROB/issue side can accept an instruction this cycle.
- `instr`  out  32  instruction presented to decode.
- `pcNumber`  out  32  word PC of `instr`.
- `available`  out  1  `instr`/`pcNumber` hold a live instruction.
- `decodePulse`  out  1  one-cycle strobe; decoder samples on its rising edge.

## Operation
- Reset values: `memReq`=0, `memAddr`=0, `instr`=0, `pcNumber`=0, `available`=0, `decodePulse`=0; FIFO empty; `fetchPc`=`RESET_PC`; both FSMs idle.
- Fetch FSM states: F_IDLE, F_WAIT, F_DROP.
  - F_IDLE: if `count` < DEPTH and no redirect: assert `memReq`, drive `memAddr`, go F_WAIT.
  - F_WAIT: on `memReady`: deassert `memReq`, push {`memData`, `fetchPc`}, `fetchPc`+1 (mod 2^32), go F_IDLE.
  - Redirect in F_WAIT without `memReady`: keep `memReq`/`memAddr` unchanged, go F_DROP.
  - F_DROP: on `memReady`: discard data, deassert `memReq`, go F_IDLE.
  - Any redirect: `fetchPc`←`redirectPc`. Redirect in F_WAIT with `memReady` the same cycle: discard, go F_IDLE.
- `count` covers queued entries plus any F_WAIT request. A request is never issued that could overflow. The FIFO never pushes when full.
- FIFO: circular buffer, pointers log2(DEPTH)+1 bits; full/empty from MSB compare; pointers wrap naturally.
- Output FSM states: O_IDLE, O_SETUP, O_PULSE.
  - O_IDLE: FIFO non-empty: pop head into `instr`/`pcNumber`, `available`←1, go O_SETUP.
  - O_SETUP: hold outputs. If `issueReady`: `decodePulse`←1, go O_PULSE. Otherwise stay; the instruction is held indefinitely.
  - O_PULSE: `decodePulse`←0. FIFO non-empty: pop next, go O_SETUP. Empty: `available`←0, go O_IDLE.
- Redirect overrides every output state. Next cycle: O_IDLE, `available`=0, `decodePulse`=0, FIFO empty. `instr`/`pcNumber` keep their last values.
- Pushes and pops in the same cycle are legal; `count` is unchanged.

## Timing
- Memory: earliest `memReq` is the first edge after reset deasserts. `memReady` is accepted the same cycle it is seen, with any latency ≥0 cycles after `memReq` rises.
- Fetch throughput is at most 1 instruction per 2 cycles, because F_IDLE is always revisited.
- Fetch to present: push at edge N, O_SETUP at edge N+1 if the output FSM is idle, `decodePulse` high from edge N+2 when `issueReady`.
- `decodePulse` is never high in consecutive cycles and is high only while `available`=1.
- Peak decode rate is 1 instruction per 2 cycles.
- Redirect takes effect on the edge that samples it. The first post-redirect `memReq` comes one edge after the stale response clears, or one edge after the redirect if nothing is outstanding.
- Reset asserted mid-transaction forces reset values immediately. Any late `memReady` is ignored while in F_IDLE.

## Test plan
- Reset: hold `reset` 3 cycles, `RESET_PC`=0. All outputs are 0. First edge after release gives `memReq`=1, `memAddr`=0x0.
- Straight line: memory answers 1 cycle after request with 0x00500093, 0x00A00113, 0x002081B3. Each shows `available`=1 with `pcNumber` 0, 1, 2 in order, then `decodePulse`=1 for exactly one cycle the next cycle.
- Backpressure: `issueReady`=0. `memReq` stops after 4 fetches (DEPTH=4 including the presented entry path). With `issueReady`=1, the entries drain in order through FIFO wrap-around over 10 instructions, with no loss or duplication.
- Redirect with outstanding request: memory stalls 5 cycles, `redirectPc`=0x40. The stale `memData` is discarded. The next `memAddr`=0x100. The first presented `pcNumber`=0x40.
- Redirect during O_SETUP with 3 queued: the next cycle shows `available`=0, `decodePulse`=0, queue empty, and no decodePulse for the flushed instructions.
- Redirect coinciding with `memReady` in F_WAIT: the data is dropped and the next request targets `redirectPc`.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: fetches words from memory into a small FIFO
// and presents each to decode one cycle ahead of a single-cycle decodePulse.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memReady,
    input  logic [31:0] memData,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    input  logic        issueReady,
    output logic [31:0] instr,
    output logic [31:0] pcNumber,
    output logic        available,
    output logic        decodePulse
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW + 2)'(DEPTH);

    typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DROP} fstate_t;
    typedef enum logic [1:0] {O_IDLE, O_SETUP, O_PULSE} ostate_t;

    fstate_t     fstate_q, fstate_d;
    ostate_t     ostate_q, ostate_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        avail_q, avail_d;
    logic        pulse_q, pulse_d;

    logic [31:0] fifo_instr_q [DEPTH];
    logic [31:0] fifo_pc_q    [DEPTH];

    logic          push, pop;
    logic          fifo_empty, fifo_full;
    logic [AW:0]   fifo_cnt;
    logic [AW+1:0] occ;
    logic          can_fetch;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                        (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign fifo_cnt   = wptr_q - rptr_q;
    // The presented instruction still occupies a slot until it is retired.
    assign occ        = {1'b0, fifo_cnt} + {{(AW + 1){1'b0}}, avail_q};
    assign can_fetch  = (occ < DEPTH_W);

    always_comb begin
        fstate_d   = fstate_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        unique case (fstate_q)
            F_IDLE: begin
                if (redirectValid) begin
                    fetch_pc_d = redirectPc;
                end else if (can_fetch) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {fetch_pc_q[29:0], 2'b00};
                    fstate_d   = F_WAIT;
                end
            end
            F_WAIT: begin
                if (memReady) begin
                    mem_req_d = 1'b0;
                    fstate_d  = F_IDLE;
                    if (redirectValid) begin
                        fetch_pc_d = redirectPc;
                    end else begin
                        push       = !fifo_full;
                        fetch_pc_d = fetch_pc_q + 32'd1;
                    end
                end else if (redirectValid) begin
                    fetch_pc_d = redirectPc;
                    fstate_d   = F_DROP;
                end
            end
            F_DROP: begin
                if (redirectValid) fetch_pc_d = redirectPc;
                if (memReady) begin
                    mem_req_d = 1'b0;
                    fstate_d  = F_IDLE;
                end
            end
            default: fstate_d = F_IDLE;
        endcase
    end

    always_comb begin
        ostate_d = ostate_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        avail_d  = avail_q;
        pulse_d  = pulse_q;
        pop      = 1'b0;
        if (redirectValid) begin
            ostate_d = O_IDLE;
            avail_d  = 1'b0;
            pulse_d  = 1'b0;
        end else begin
            unique case (ostate_q)
                O_IDLE: begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        instr_d  = fifo_instr_q[rptr_q[AW-1:0]];
                        pc_d     = fifo_pc_q[rptr_q[AW-1:0]];
                        avail_d  = 1'b1;
                        ostate_d = O_SETUP;
                    end
                end
                O_SETUP: begin
                    if (issueReady) begin
                        pulse_d  = 1'b1;
                        ostate_d = O_PULSE;
                    end
                end
                O_PULSE: begin
                    pulse_d = 1'b0;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        instr_d  = fifo_instr_q[rptr_q[AW-1:0]];
                        pc_d     = fifo_pc_q[rptr_q[AW-1:0]];
                        ostate_d = O_SETUP;
                    end else begin
                        avail_d  = 1'b0;
                        ostate_d = O_IDLE;
                    end
                end
                default: ostate_d = O_IDLE;
            endcase
        end
    end

    always_comb begin
        if (redirectValid) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            wptr_d = wptr_q + {{AW{1'b0}}, push};
            rptr_d = rptr_q + {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fstate_q   <= F_IDLE;
            ostate_q   <= O_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            instr_q    <= '0;
            pc_q       <= '0;
            avail_q    <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            fstate_q   <= fstate_d;
            ostate_q   <= ostate_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            avail_q    <= avail_d;
            pulse_q    <= pulse_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_instr_q[wptr_q[AW-1:0]] <= memData;
            fifo_pc_q[wptr_q[AW-1:0]]    <= fetch_pc_q;
        end
    end

    assign memReq      = mem_req_q;
    assign memAddr     = mem_addr_q;
    assign instr       = instr_q;
    assign pcNumber    = pc_q;
    assign available   = avail_q;
    assign decodePulse = pulse_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios then random traffic,
// with decoded instructions checked against an in-order PC stream model.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memReady;
    logic [31:0] memData;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        issueReady;
    logic [31:0] instr;
    logic [31:0] pcNumber;
    logic        available;
    logic        decodePulse;

    always #5 clock = ~clock;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock(clock),
        .reset(reset),
        .memReq(memReq),
        .memAddr(memAddr),
        .memReady(memReady),
        .memData(memData),
        .redirectValid(redirectValid),
        .redirectPc(redirectPc),
        .issueReady(issueReady),
        .instr(instr),
        .pcNumber(pcNumber),
        .available(available),
        .decodePulse(decodePulse)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          accepted, decoded, wcnt, lat, lat_fix, base;
    bit          stale;
    logic [31:0] expected_pc, addr_hold;
    logic        prev_avail, prev_pulse;

    function automatic logic [31:0] golden(input logic [31:0] pc);
        case (pc)
            32'd0:   return 32'h00500093;
            32'd1:   return 32'h00A00113;
            32'd2:   return 32'h002081B3;
            default: return (pc * 32'h9E3779B1) ^ 32'h13;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory: answers each request after lat cycles with golden(word addr).
    task automatic drive_mem();
        if (memReq) begin
            if (wcnt > 0) check("addr_stable", memAddr, addr_hold);
            addr_hold = memAddr;
            memReady  = (wcnt >= lat);
            memData   = memReady ? golden({2'b00, memAddr[31:2]}) : $urandom;
            wcnt++;
        end else begin
            wcnt     = 0;
            memReady = 1'b0;
            memData  = '0;
            lat      = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
        end
    endtask

    // Apply the current inputs for one edge, update the model, check outputs.
    task automatic tick();
        if (redirectValid) begin
            stale       = memReq && !memReady;
            expected_pc = redirectPc;
            accepted    = decoded;
        end else if (memReq && memReady) begin
            if (stale) stale = 1'b0;
            else accepted++;
        end
        prev_avail = available;
        prev_pulse = decodePulse;
        @(posedge clock);
        @(negedge clock);
        if (decodePulse) begin
            check("pulse_pc", pcNumber, expected_pc);
            check("pulse_instr", instr, golden(expected_pc));
            check("pulse_shape", {available, prev_avail, prev_pulse}, 3'b110);
            expected_pc++;
            decoded++;
        end
        if (accepted - decoded > DEPTH)
            check("occupancy", accepted - decoded, DEPTH);
        redirectValid = 1'b0;
        drive_mem();
    endtask

    initial begin
        reset         = 1'b1;
        memReady      = 1'b0;
        memData       = '0;
        redirectValid = 1'b0;
        redirectPc    = '0;
        issueReady    = 1'b0;
        lat_fix       = 1;
        lat           = 1;
        wcnt          = 0;
        accepted      = 0;
        decoded       = 0;
        stale         = 1'b0;
        expected_pc   = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_memReq", memReq, 0);
        check("rst_memAddr", memAddr, 0);
        check("rst_instr", instr, 0);
        check("rst_pcNumber", pcNumber, 0);
        check("rst_available", available, 0);
        check("rst_decodePulse", decodePulse, 0);

        reset = 1'b0;
        tick();
        check("first_req", memReq, 1);
        check("first_addr", memAddr, 32'h0);

        // Straight-line fetch and decode
        issueReady = 1'b1;
        for (int i = 0; i < 60 && decoded < 3; i++) tick();
        check("straight_count", decoded, 3);

        // Backpressure fills the queue, then drains in order
        issueReady = 1'b0;
        repeat (30) tick();
        check("bp_fetches", accepted - decoded, DEPTH);
        check("bp_noreq", memReq, 0);
        base       = decoded;
        issueReady = 1'b1;
        for (int i = 0; i < 300 && decoded < base + 10; i++) tick();
        check("bp_drain", decoded - base, 10);

        // Redirect with a stalled outstanding request
        lat_fix = 5;
        for (int i = 0; i < 20 && memReq; i++) tick();
        for (int i = 0; i < 20 && !memReq; i++) tick();
        check("stall_req_seen", memReq && !memReady && !stale, 1);
        redirectValid = 1'b1;
        redirectPc    = 32'h40;
        tick();
        lat_fix = 1;
        for (int i = 0; i < 20 && memReq; i++) tick();
        for (int i = 0; i < 20 && !memReq; i++) tick();
        check("stall_redir_addr", memAddr, 32'h100);
        base = decoded;
        for (int i = 0; i < 50 && decoded == base; i++) tick();
        check("stall_redir_decode", decoded - base, 1);

        // Redirect while an instruction is presented with three queued
        issueReady = 1'b0;
        repeat (30) tick();
        check("setup_fill", accepted - decoded, DEPTH);
        redirectValid = 1'b1;
        redirectPc    = 32'h300;
        tick();
        check("setup_flush_avail", available, 0);
        check("setup_flush_pulse", decodePulse, 0);
        for (int i = 0; i < 20 && !available; i++) tick();
        check("setup_next_pc", pcNumber, 32'h300);
        issueReady = 1'b1;

        // Redirect coinciding with memReady
        lat_fix = 2;
        for (int i = 0; i < 20 && memReq; i++) tick();
        for (int i = 0; i < 20 && !(memReq && memReady); i++) tick();
        check("coin_ready_seen", memReq && memReady && !stale, 1);
        redirectValid = 1'b1;
        redirectPc    = 32'h80;
        tick();
        for (int i = 0; i < 20 && memReq; i++) tick();
        for (int i = 0; i < 20 && !memReq; i++) tick();
        check("coin_redir_addr", memAddr, 32'h200);
        base = decoded;
        for (int i = 0; i < 50 && decoded == base; i++) tick();
        check("coin_redir_decode", decoded - base, 1);

        // Random traffic
        lat_fix = -1;
        base    = decoded;
        repeat (400) begin
            issueReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                redirectValid = 1'b1;
                redirectPc    = $urandom_range(0, 32'hFFFFF);
            end
            tick();
        end
        check("random_progress", (decoded - base) > 10, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
